bram_port_arbiter: RTL and testbench

- Shares the single-port 32-bit block RAM between two requesters: requester 0 is the CPU memory port, requester 1 is the debug/program loader port.
- Accepts at most one access per cycle and registers it onto the RAM port.
- Steers the 1-cycle-latency read data back to the requester that issued the read.
- Round-robin priority with an optional lock; a hold limit bounds starvation.

---
 rtl/bram_port_arbiter_if.sv | 40 ++++
 rtl/bram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the two BRAM requesters, the arbiter and the RAM port.
// master: requesters + RAM side; slave: the arbiter.
interface bram_port_arbiter_if #(
    parameter int SIZE = 10
);
    logic            req0;
    logic            req1;
    logic            we0;
    logic            we1;
    logic            lock0;
    logic            lock1;
    logic [SIZE-1:0] addr0;
    logic [SIZE-1:0] addr1;
    logic [31:0]     wdata0;
    logic [31:0]     wdata1;
    logic            gnt0;
    logic            gnt1;
    logic            rvalid0;
    logic            rvalid1;
    logic [31:0]     rdata0;
    logic [31:0]     rdata1;
    logic            ram_we;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter (lock + hold limit) in front of a single-port
// BRAM. Optional grant/conflict counters: define ARB_STATS_EN.
module bram_port_arbiter #(
    parameter int SIZE     = 10,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1,
    output logic [15:0] conflict_cnt,
`endif
    bram_port_arbiter_if.slave bus
);
    logic            r_rr;
    logic            r_own_v;
    logic            r_own;
    logic [7:0]      r_hold;
    logic            r_tag1_v;
    logic            r_tag1_id;
    logic            r_tag2_v;
    logic            r_tag2_id;
    logic            r_ram_we;
    logic [SIZE-1:0] r_ram_addr;
    logic [31:0]     r_ram_wdata;

    logic            w_both;
    logic            w_keep;
    logic            w_g0;
    logic            w_g1;
    logic            w_gnt;
    logic            w_id;
    logic            w_we;
    logic            w_lock;
    logic            w_other;
    logic [SIZE-1:0] w_addr;
    logic [31:0]     w_wdata;

    // Grants are gated by reset so nothing is accepted while it is held.
    always_comb begin
        w_both = bus.req0 & bus.req1;
        w_keep = r_own_v & (r_own ? bus.lock1 : bus.lock0)
                 & (r_hold < 8'(MAX_HOLD));
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (!rst) begin
            w_g0 = 1'b0;
            w_g1 = 1'b0;
        end else if (w_both) begin
            w_g1 = w_keep ? r_own : r_rr;
            w_g0 = ~w_g1;
        end else begin
            w_g0 = bus.req0;
            w_g1 = bus.req1;
        end
        w_gnt   = w_g0 | w_g1;
        w_id    = w_g1;
        w_we    = w_id ? bus.we1 : bus.we0;
        w_lock  = w_id ? bus.lock1 : bus.lock0;
        w_other = w_id ? bus.req0 : bus.req1;
        w_addr  = w_id ? bus.addr1 : bus.addr0;
        w_wdata = w_id ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr        <= 1'b0;
            r_own_v     <= 1'b0;
            r_own       <= 1'b0;
            r_hold      <= 8'd0;
            r_tag1_v    <= 1'b0;
            r_tag1_id   <= 1'b0;
            r_tag2_v    <= 1'b0;
            r_tag2_id   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'd0;
        end else begin
            r_tag2_v  <= r_tag1_v;
            r_tag2_id <= r_tag1_id;
            r_tag1_v  <= w_gnt & ~w_we;
            r_tag1_id <= w_id;
            r_ram_we  <= w_gnt & w_we;
            if (w_gnt) begin
                r_ram_addr  <= w_addr;
                r_ram_wdata <= w_wdata;
                r_rr        <= ~w_id;
                r_own_v     <= w_lock;
                r_own       <= w_id;
                if (!w_other)
                    r_hold <= 8'd0;
                else if (r_own_v && (r_own == w_id))
                    r_hold <= (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
                else
                    r_hold <= 8'd1;
            end else begin
                r_hold <= 8'd0;
            end
        end
    end

    assign bus.gnt0      = w_g0;
    assign bus.gnt1      = w_g1;
    assign bus.rvalid0   = r_tag2_v & ~r_tag2_id;
    assign bus.rvalid1   = r_tag2_v & r_tag2_id;
    assign bus.rdata0    = bus.rvalid0 ? bus.ram_rdata : 32'd0;
    assign bus.rdata1    = bus.rvalid1 ? bus.ram_rdata : 32'd0;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

`ifdef ARB_STATS_EN
    logic [15:0] r_gc0;
    logic [15:0] r_gc1;
    logic [15:0] r_cc;

    // Clear wins over increment; all counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gc0 <= 16'd0;
            r_gc1 <= 16'd0;
            r_cc  <= 16'd0;
        end else if (stats_clr) begin
            r_gc0 <= 16'd0;
            r_gc1 <= 16'd0;
            r_cc  <= 16'd0;
        end else begin
            if (w_g0 && (r_gc0 != 16'hFFFF)) r_gc0 <= r_gc0 + 16'd1;
            if (w_g1 && (r_gc1 != 16'hFFFF)) r_gc1 <= r_gc1 + 16'd1;
            if (w_both && (r_cc != 16'hFFFF)) r_cc <= r_cc + 16'd1;
        end
    end

    assign gnt_cnt0     = r_gc0;
    assign gnt_cnt1     = r_gc1;
    assign conflict_cnt = r_cc;
`endif
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter with an in-bench reference model
// of arbitration, RAM contents and read return; directed cases pin the model.
module tb_bram_port_arbiter;
  localparam int AW = 10;
  localparam int MH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.SIZE(AW)) bus();

`ifdef ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] gc0, gc1, cc;
`endif

  bram_port_arbiter #(.SIZE(AW), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ARB_STATS_EN
    .stats_clr(stats_clr),
    .gnt_cnt0(gc0),
    .gnt_cnt1(gc1),
    .conflict_cnt(cc),
`endif
    .bus(bus)
  );

  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  typedef struct {
    int          due;
    int          id;
    logic [31:0] d;
  } rd_t;

  logic [31:0]   mm [0:(1<<AW)-1];
  rd_t           pend[$];
  int            rr, own, hold, cyc;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wd;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [AW-1:0] s_addr;
  logic          s_rv0, s_rv1;
  logic [31:0]   s_rd0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask

  function automatic bit lk(int i);
    return (i != 0) ? bus.lock1 : bus.lock0;
  endfunction

  task automatic mreset();
    rr = 0; own = -1; hold = 0;
    exp_we = 1'b0; exp_addr = '0; exp_wd = 32'd0;
    pend.delete();
  endtask

  task automatic step(output int g);
    int            eg;
    bit            ev;
    int            eid;
    logic [31:0]   ed;
    bit            ow, we;
    logic [AW-1:0] a;
    logic [31:0]   d;
    @(negedge clk);
    eg = -1;
    if (rst) begin
      if (bus.req0 && bus.req1)
        eg = (own >= 0 && lk(own) && hold < MH) ? own : rr;
      else if (bus.req0) eg = 0;
      else if (bus.req1) eg = 1;
    end
    chk("gnt0", 32'(bus.gnt0), 32'(eg == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(eg == 1));
    chk("ram_we", 32'(bus.ram_we), 32'(exp_we));
    chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
    chk("ram_wdata", bus.ram_wdata, exp_wd);
    ev = 0; eid = 0; ed = 32'd0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1; eid = pend[0].id; ed = pend[0].d;
      void'(pend.pop_front());
    end
    chk("rvalid0", 32'(bus.rvalid0), 32'(ev && eid == 0));
    chk("rdata0", bus.rdata0, (ev && eid == 0) ? ed : 32'd0);
    chk("rvalid1", 32'(bus.rvalid1), 32'(ev && eid == 1));
    chk("rdata1", bus.rdata1, (ev && eid == 1) ? ed : 32'd0);
    s_addr = bus.ram_addr;
    s_rv0 = bus.rvalid0; s_rd0 = bus.rdata0; s_rv1 = bus.rvalid1;
    g = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
    @(posedge clk);
    if (!rst) mreset();
    else if (eg < 0) begin
      exp_we = 1'b0;
      hold = 0;
    end else begin
      ow = (eg != 0) ? bus.req0 : bus.req1;
      we = (eg != 0) ? bus.we1 : bus.we0;
      a  = (eg != 0) ? bus.addr1 : bus.addr0;
      d  = (eg != 0) ? bus.wdata1 : bus.wdata0;
      exp_we = we; exp_addr = a; exp_wd = d;
      if (we) mm[a] = d;
      else pend.push_back('{cyc + 2, eg, mm[a]});
      if (!ow) hold = 0;
      else if (own == eg) hold = hold + 1;
      else hold = 1;
      own = lk(eg) ? eg : -1;
      rr = 1 - eg;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b0;
    #1;
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    mreset();
    repeat (2) begin
      step(g);
      chk("rst_rvalid0", 32'(s_rv0), 32'd0);
    end
    rst = 1'b1;
  endtask

  task automatic setq(int i, bit r, bit w, bit l, int a, logic [31:0] d);
    if (i == 0) begin
      bus.req0 = r; bus.we0 = w; bus.lock0 = l;
      bus.addr0 = AW'(a); bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.lock1 = l;
      bus.addr1 = AW'(a); bus.wdata1 = d;
    end
  endtask

  task automatic nreq(int i);
    bit r = ($urandom_range(0, 3) != 0);
    bit w = $urandom_range(0, 1) == 1;
    bit l = ($urandom_range(0, 2) == 0);
    setq(i, r, w, l, $urandom_range(0, 15), $urandom);
  endtask

  initial begin
    int g;
    int seq3 [5];
    seq3 = '{0, 1, 1, 1, 0};
    g = -1;
    cyc = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = $urandom;
      mm[i] = ram[i];
    end
    ram[5] = 32'h1234;
    mm[5] = 32'h1234;
    setq(0, 0, 0, 0, 0, 0);
    setq(1, 0, 0, 0, 0, 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt0", 32'(bus.gnt0), 32'd0);
    chk("reset_ram_we", 32'(bus.ram_we), 32'd0);
    chk("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("reset_rvalid0", 32'(bus.rvalid0), 32'd0);
    rst = 1'b1;

    setq(0, 1, 0, 0, 5, 0);
    step(g);
    chk("t1_gnt", 32'(g), 32'd0);
    setq(0, 0, 0, 0, 5, 0);
    step(g);
    chk("t1_ram_addr", 32'(s_addr), 32'd5);
    step(g);
    chk("t1_rvalid0", 32'(s_rv0), 32'd1);
    chk("t1_rdata0", s_rd0, 32'h1234);
    chk("t1_rvalid1", 32'(s_rv1), 32'd0);

    do_reset();
    setq(0, 1, 0, 0, 1, 0);
    setq(1, 1, 0, 0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      step(g);
      chk("t2_rr_order", 32'(g), 32'(k % 2));
    end
    setq(0, 0, 0, 0, 0, 0);
    setq(1, 0, 0, 0, 0, 0);
    repeat (2) step(g);

    do_reset();
    setq(0, 1, 0, 0, 3, 0);
    setq(1, 1, 0, 1, 4, 0);
    for (int k = 0; k < 5; k++) begin
      step(g);
      chk("t3_hold_order", 32'(g), 32'(seq3[k]));
    end
    setq(0, 0, 0, 0, 0, 0);
    setq(1, 1, 1, 0, 7, 32'hDEAD);
    repeat (2) step(g);

    setq(1, 1, 1, 0, 7, 32'hDEAD);
    step(g);
    chk("t4_wr_gnt", 32'(g), 32'd1);
    setq(1, 0, 0, 0, 0, 0);
    setq(0, 1, 0, 0, 7, 0);
    step(g);
    chk("t4_rd_gnt", 32'(g), 32'd0);
    setq(0, 0, 0, 0, 0, 0);
    step(g);
    step(g);
    chk("t4_raw_rvalid0", 32'(s_rv0), 32'd1);
    chk("t4_raw_rdata0", s_rd0, 32'hDEAD);

    setq(0, 1, 0, 0, 9, 0);
    step(g);
    setq(0, 0, 0, 0, 0, 0);
    do_reset();
    setq(0, 1, 0, 0, 1, 0);
    setq(1, 1, 0, 0, 2, 0);
    step(g);
    chk("t5_post_reset_gnt", 32'(g), 32'd0);
    setq(0, 0, 0, 0, 0, 0);
    setq(1, 0, 0, 0, 0, 0);
    repeat (2) step(g);

`ifdef ARB_STATS_EN
    do_reset();
    setq(0, 1, 0, 0, 1, 0);
    setq(1, 1, 0, 0, 2, 0);
    repeat (10) step(g);
    chk("st_conflict", 32'(cc), 32'd10);
    chk("st_gnt0", 32'(gc0), 32'd5);
    chk("st_gnt1", 32'(gc1), 32'd5);
    setq(0, 0, 0, 0, 0, 0);
    setq(1, 0, 0, 0, 0, 0);
    stats_clr = 1'b1;
    step(g);
    stats_clr = 1'b0;
    chk("st_clr_conflict", 32'(cc), 32'd0);
    chk("st_clr_gnt0", 32'(gc0), 32'd0);
    chk("st_clr_gnt1", 32'(gc1), 32'd0);
    repeat (2) step(g);
`endif

    g = -1;
    for (int k = 0; k < 3000; k++) begin
      if (!bus.req0 || g == 0) nreq(0);
      if (!bus.req1 || g == 1) nreq(1);
      if (k == 1500) do_reset();
      step(g);
    end
    setq(0, 0, 0, 0, 0, 0);
    setq(1, 0, 0, 0, 0, 0);
    repeat (3) step(g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
